// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the CSA adder tree and its front-end frame packer.
// Both sides derive their widths from here so they cannot diverge.
package adder_tree_pkg;

    // Number of 3:2 compressor stages needed to reduce n operands down to two.
    function automatic int unsigned StageCount(input int unsigned n);
        int unsigned k;
        int unsigned s;
        k = n;
        s = 0;
        while (k > 2) begin
            k = k - k / 3;
            s = s + 1;
        end
        return s;
    endfunction

    function automatic int unsigned OutWidth(input int unsigned w, input int unsigned n);
        return w + StageCount(n) + 2;
    endfunction

    function automatic int unsigned LaneWidth(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned TREE_DATA_W = 3;
    localparam int unsigned TREE_DATA_N = 4;
    localparam int unsigned TREE_OUT_W  = OutWidth(TREE_DATA_W, TREE_DATA_N);

endpackage

// File: rtl/adder_tree_frame_packer.sv
// Packs a valid-qualified sample stream into zero-padded I_DATA_N-lane frames for the adder tree.
// Frames close on the N-th sample or on i_last; i_flush drops the partial frame.
module adder_tree_frame_packer
    import adder_tree_pkg::*;
#(
    parameter int unsigned I_DATA_W = 3,
    parameter int unsigned I_DATA_N = 4,
    localparam int unsigned LANE_W  = LaneWidth(I_DATA_N)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [I_DATA_W-1:0]                   i_data,
    input  logic                                  i_last,
    input  logic                                  i_flush,
    output logic [0:I_DATA_N-1][I_DATA_W-1:0]     o_data,
    output logic                                  o_valid,
    output logic [LANE_W-1:0]                     o_lanes,
    output logic [15:0]                           o_frame_cnt
);

    localparam int unsigned PTR_W = $clog2(I_DATA_N);

    logic [0:I_DATA_N-1][I_DATA_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0]                  ptr_q, ptr_d;
    logic [0:I_DATA_N-1][I_DATA_W-1:0] data_d;
    logic                              valid_d;
    logic [LANE_W-1:0]                 lanes_d;
    logic [15:0]                       cnt_d;
    logic                              close;

    assign close = i_valid && !i_flush && (i_last || (ptr_q == PTR_W'(I_DATA_N - 1)));

    always_comb begin
        fill_d  = fill_q;
        ptr_d   = ptr_q;
        data_d  = o_data;
        valid_d = 1'b0;
        lanes_d = o_lanes;
        cnt_d   = o_frame_cnt;
        if (i_flush) begin
            fill_d = '0;
            ptr_d  = '0;
        end else if (close) begin
            // Lanes above ptr are zeroed so the tree sum covers only real samples.
            for (int i = 0; i < int'(I_DATA_N); i++) begin
                if (PTR_W'(i) < ptr_q) begin
                    data_d[i] = fill_q[i];
                end else if (PTR_W'(i) == ptr_q) begin
                    data_d[i] = i_data;
                end else begin
                    data_d[i] = '0;
                end
            end
            valid_d = 1'b1;
            lanes_d = LANE_W'(ptr_q) + LANE_W'(1);
            cnt_d   = o_frame_cnt + 16'd1;
            fill_d  = '0;
            ptr_d   = '0;
        end else if (i_valid) begin
            fill_d[ptr_q] = i_data;
            ptr_d         = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q      <= '0;
            ptr_q       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_lanes     <= '0;
            o_frame_cnt <= '0;
        end else begin
            fill_q      <= fill_d;
            ptr_q       <= ptr_d;
            o_data      <= data_d;
            o_valid     <= valid_d;
            o_lanes     <= lanes_d;
            o_frame_cnt <= cnt_d;
        end
    end

endmodule
